// File: rtl/npu_pkg.sv
// Shared NPU definitions: window geometry and the MAC sequencer state encoding.
package npu_pkg;
  localparam int LANES  = 9;
  localparam int BYTE_W = 8;
  localparam int WIN_W  = LANES * BYTE_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;
endpackage

// File: rtl/mac_token_pipe.sv
// Valid-token shift register that tracks operands travelling through the
// fixed-latency PPG/Wallace datapath. tok_out marks the cycle tree_sum is valid.
module mac_token_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic tok_in,
  output logic tok_out
);
  logic [DEPTH-1:0] vld_pipe;

  // Shift one token per cycle; synchronous clear drops anything in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= tok_in;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign tok_out = vld_pipe[DEPTH-1];
endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequences one 3x3 conv output pixel: issues NUM_CH windows to the external
// 9-lane Booth/Wallace datapath, accumulates the returned sums, and hands the
// pixel result downstream over valid/ready.
// Build option: define CONV_MAC_RELU_EN to rectify out_data (negatives -> 0).
module conv_mac_sequencer
  import npu_pkg::*;
#(
  parameter int TREE_LAT = 2,
  parameter int SUM_W    = 20,
  parameter int ACC_W    = 32,
  parameter int CH_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CH_W-1:0]  cfg_num_ch,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIN_W-1:0] in_md,
  input  logic [WIN_W-1:0] in_mr,
  output logic [WIN_W-1:0] mul_md,
  output logic [WIN_W-1:0] mul_mr,
  output logic             mul_issue,
  input  logic [SUM_W-1:0] tree_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy
);
  state_e            state;
  logic [CH_W-1:0]   num_ch, issued, returned;
  logic [CH_W-1:0]   issued_nx, cfg_n;
  logic [ACC_W-1:0]  acc, sum_ext;
  logic              accept, tok_out, pix_done;

  assign accept    = in_valid && in_ready;
  assign pix_done  = (state == OUT) && out_ready;
  assign issued_nx = issued + 1'b1;
  assign cfg_n     = (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;
  assign sum_ext   = {{(ACC_W-SUM_W){tree_sum[SUM_W-1]}}, tree_sum};

  // Operand register toward the datapath; mul_issue pulses the cycle after accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mul_md    <= '0;
      mul_mr    <= '0;
      mul_issue <= 1'b0;
    end else begin
      mul_issue <= accept;
      if (accept) begin
        mul_md <= in_md;
        mul_mr <= in_mr;
      end
    end
  end

  mac_token_pipe #(.DEPTH(TREE_LAT)) u_tok (
    .clk     (clk),
    .clr     (!reset_n),
    .tok_in  (mul_issue),
    .tok_out (tok_out)
  );

  // Accumulate returned sums; the first return of a pixel loads so no explicit acc clear is needed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc      <= '0;
      returned <= '0;
    end else if (pix_done) begin
      returned <= '0;
    end else if (tok_out) begin
      acc      <= (returned == '0) ? sum_ext : acc + sum_ext;
      returned <= returned + 1'b1;
    end
  end

  // Pixel FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      num_ch    <= '0;
      issued    <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (accept) begin
            num_ch <= cfg_n;
            issued <= CH_W'(1);
            busy   <= 1'b1;
            if (cfg_n == CH_W'(1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            issued <= issued_nx;
            if (issued_nx == num_ch) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // returned is already updated with the final token when this fires.
          if (returned == num_ch) begin
            state     <= OUT;
            out_valid <= 1'b1;
`ifdef CONV_MAC_RELU_EN
            out_data  <= acc[ACC_W-1] ? '0 : acc;
`else
            out_data  <= acc;
`endif
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            issued    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer with a behavioural 2-cycle tree model.
module tb_conv_mac_sequencer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  cfg_num_ch;
  logic        in_valid, in_ready;
  logic [71:0] in_md, in_mr, mul_md, mul_mr;
  logic        mul_issue;
  logic [19:0] tree_sum, st1;
  logic        out_valid, out_ready, busy;
  logic [31:0] out_data;

  int checks = 0;
  int failures = 0;
  int n_issue = 0;

  conv_mac_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cfg_num_ch(cfg_num_ch),
    .in_valid(in_valid), .in_ready(in_ready), .in_md(in_md), .in_mr(in_mr),
    .mul_md(mul_md), .mul_mr(mul_mr), .mul_issue(mul_issue), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] lane_sum(input logic [71:0] md, input logic [71:0] mr);
    int s;
    logic signed [7:0] a, b;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      a = md[71-8*i -: 8];
      b = mr[71-8*i -: 8];
      s += int'(a) * int'(b);
    end
    return s[19:0];
  endfunction

  // Reference datapath: sum registered, then output registered (TREE_LAT=2).
  always @(posedge clk) begin
    st1      <= lane_sum(mul_md, mul_mr);
    tree_sum <= st1;
  end

  always @(negedge clk) if (mul_issue) n_issue++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(act), $signed(exp));
    end
  endtask

  task automatic send(input logic [71:0] md, input logic [71:0] mr);
    int t;
    in_md = md; in_mr = mr; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) break;
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cyc, base;
    logic [31:0] held;
    logic [71:0] ones, m128, twos, threes, p5, m20, one0;
    ones = {9{8'h01}}; m128 = {9{8'h80}}; twos = {9{8'h02}}; threes = {9{8'h03}};
    p5 = {8'd5, 64'd0}; m20 = {8'hEC, 64'd0}; one0 = {8'd1, 64'd0};
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_num_ch = 8'd1;
    in_md = '0; in_mr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_issue", 32'(mul_issue), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_mul_md", 32'(mul_md[71:64]), 0);
    reset_n = 1'b1;

    // 1: N=1, unit operands, latency 4
    send(ones, ones);
    wait_out(cyc);
    chk("t1_latency", cyc, 4);
    chk("t1_data", out_data, 9);
    take_out();

    // 2: N=3, -128*-128 on every lane
    cfg_num_ch = 8'd3; base = n_issue;
    send(m128, m128); send(m128, m128); send(m128, m128);
    wait_out(cyc);
    chk("t2_out_valid", 32'(out_valid), 1);
    chk("t2_data", out_data, 32'd442368);
    chk("t2_issues", n_issue - base, 3);
    take_out();

    // 3: N=2, +5 then -20
    cfg_num_ch = 8'd2;
    send(p5, one0); send(m20, one0);
    wait_out(cyc);
`ifdef CONV_MAC_RELU_EN
    chk("t3_data", out_data, 0);
`else
    chk("t3_data", out_data, 32'hFFFF_FFF1);
`endif
    take_out();

    // 4: backpressure in OUT, inputs blocked and result stable
    cfg_num_ch = 8'd1;
    send(ones, twos);
    wait_out(cyc);
    held = out_data;
    chk("t4_data", held, 18);
    base = n_issue;
    in_valid = 1'b1; in_md = threes; in_mr = threes;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_in_ready", 32'(in_ready), 0);
      chk("t4_stable", out_data, held);
    end
    chk("t4_valid_held", 32'(out_valid), 1);
    chk("t4_no_issue", n_issue - base, 0);
    in_valid = 1'b0;
    take_out();
    send(ones, ones);
    wait_out(cyc);
    chk("t4_next", out_data, 9);
    take_out();

    // 5: reset during DRAIN of N=4
    cfg_num_ch = 8'd4;
    send(ones, ones); send(ones, ones); send(ones, ones); send(ones, ones);
    chk("t5_busy", 32'(busy), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_in_ready", 32'(in_ready), 0);
    chk("t5_issue", 32'(mul_issue), 0);
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_busy_rst", 32'(busy), 0);
    chk("t5_out_data", out_data, 0);
    reset_n = 1'b1;
    cfg_num_ch = 8'd1;
    send(twos, threes);
    wait_out(cyc);
    chk("t5_data", out_data, 54);
    take_out();

    // 6: cfg 0 -> 1; cfg change mid-ISSUE ignored
    cfg_num_ch = 8'd0; base = n_issue;
    send(ones, ones);
    wait_out(cyc);
    chk("t6_zero_data", out_data, 9);
    chk("t6_zero_issues", n_issue - base, 1);
    take_out();
    cfg_num_ch = 8'd2; base = n_issue;
    send(ones, ones);
    cfg_num_ch = 8'd5;
    send(ones, twos);
    chk("t6_drain_ready", 32'(in_ready), 0);
    wait_out(cyc);
    chk("t6_out_valid", 32'(out_valid), 1);
    chk("t6_data", out_data, 27);
    chk("t6_issues", n_issue - base, 2);
    take_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
